uart_frame_receiver: RTL and testbench
======================================

Name: uart_frame_receiver

Overview:
- Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit.
- Used by the bench as the telemetry monitor on the eBike TX line; the eBike sends battery, torque and current packets over it.
- Presents each received byte on rx_data and raises a rdy flag, which the consumer clears with clr_rdy.
- Runs entirely in the system clock domain; the RX input is asynchronous.

Parameters:
- BAUD_DIV, 2604: system clocks per bit (50 MHz / 19200 baud). Legal range 16..65535.
- HALF_DIV, BAUD_DIV/2 (1302): clocks from start-bit edge to the first mid-bit sample.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial line, idles high; asynchronous.
- clr_rdy  in  1  clears rdy; may be tied to rdy to form a one-cycle strobe.
- rdy  out  1  high when a new byte is valid.
- rx_data  out  8  last received byte.

Behaviour:
- Reset:
  - synchronizer flops preset to 1.
  - rdy = 0, rx_data = 8'h00, state IDLE.
  - bit counter = 0, baud counter = 0.
- Synchronizer: RX passes through two flops (rx_s). Start-edge detection uses rx_s plus one further flop (falling edge = prev 1, now 0).
- States: IDLE, START, DATA, STOP.
- IDLE:
  - on a falling edge of rx_s, load baud_cnt = HALF_DIV and go to START.
  - If this is also the clr_rdy cycle, clear rdy. Otherwise rdy is left untouched; it is cleared only by clr_rdy or reset.
- baud_cnt decrements each clock in START/DATA/STOP. A sample occurs when it reaches 0; it then reloads with BAUD_DIV.
- START sample:
  - rx_s = 1 → glitch; return to IDLE with no output change.
  - rx_s = 0 → go to DATA with bit_cnt = 0.
- DATA sample:
  - shift rx_s into shift_reg MSB, shifting right.
  - bit_cnt increments; after the 8th sample go to STOP.
- STOP sample:
  - rx_data <= shift_reg in the same cycle; rdy set next edge (registered).
  - go to IDLE regardless of the sampled stop value.
- Latency: rdy rises HALF_DIV + 9*BAUD_DIV + 3 (±1) clocks after the RX falling edge (24741 clocks at default).
- Back-to-back frames:
  - a start edge arriving while rdy = 1 is accepted; rdy stays set until cleared.
  - a new completion overwrites rx_data.
- rdy set vs clr_rdy in the same cycle: set wins. Therefore clr_rdy = rdy yields exactly one high cycle per byte.
- rx_data holds its value between frames; it is not cleared by clr_rdy.
- Reset mid-frame: the frame is abandoned and all registers return to reset values.
- Line held low (break): one frame is received with data 0; no further frames until rx_s returns high and falls again.

Optional Feature:
- Macro UART_RX_FRAME_ERR_EN.
- Defined:
  - adds output frame_err (1 bit, reset 0).
  - frame_err is set, together with rdy, when the stop-bit sample is 0.
  - frame_err is cleared by clr_rdy or by the next good frame.
  - rx_data is still updated.
- Undefined: no port; the stop bit is ignored.

Decomposition:
- Package uart_rx_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - localparam DEF_BAUD_DIV = 2604.
  - localparam DATA_BITS = 8.
- Sub-module rx_sync2: 2-flop synchronizer, reset value 1, parameterized width. Instantiated once.

Test Plan:
- Reset with RX = 1 → rdy = 0, rx_data = 00; no activity for 50000 clocks.
- Send byte 8'hA5 at 19200 baud, clr_rdy tied to rdy → rdy high for exactly 1 clock at 24741±1 clocks after the start edge; rx_data = A5.
- Glitch test: RX low for 500 clocks, then high → rdy stays 0 and the FSM returns to IDLE.
- Two back-to-back frames 8'h3C, 8'hC3 with clr_rdy = 0 → rdy stays 1 after the first; rx_data = C3 after the second.
- Stop bit forced 0 on frame 8'h7E, macro defined → frame_err = 1 with rdy; rx_data = 7E. Macro undefined → only rdy.
- Assert rst_n low in the middle of data bit 4 → rdy = 0, state IDLE. A subsequent clean frame 8'h11 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART frame receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned DEF_BAUD_DIV = 2604;
    localparam int unsigned DATA_BITS    = 8;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for asynchronous inputs; flops preset to 1 so an
// idle-high serial line reads as idle straight out of reset.
module rx_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: 1 start bit, 8 data bits LSB-first, 1 stop bit.
// Received byte appears on rx_data and rdy is raised one clock after the
// stop-bit sample; the consumer clears rdy with clr_rdy (set wins).
// Optional: define UART_RX_FRAME_ERR_EN to add the frame_err output,
// flagged alongside rdy when the stop-bit sample is 0.
module uart_frame_receiver
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV,
    parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam logic [15:0] BAUD_LD  = 16'(BAUD_DIV);
    localparam logic [15:0] HALF_LD  = 16'(HALF_DIV);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    logic       rx_s;
    logic       rx_prev_q;
    logic       fall_edge;

    rx_state_t  state_q,    state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] baud_dec;
    logic [3:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] shift_q,    shift_d;
    logic [7:0] data_q,     data_d;
    logic       set_q,      set_d;
    logic       rdy_q,      rdy_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic       err_pend_q, err_pend_d;
    logic       ferr_q,     ferr_d;
`endif

    rx_sync2 #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (RX),
        .q_o   (rx_s)
    );

    assign fall_edge = rx_prev_q & ~rx_s;
    assign baud_dec  = baud_cnt_q - 16'd1;

    // Next-state logic: frame FSM, bit sampling and rdy/flag handling.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        set_d      = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        err_pend_d = err_pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    baud_cnt_d = HALF_LD;
                    state_d    = START;
                end
            end
            START: begin
                baud_cnt_d = baud_dec;
                if (baud_dec == '0) begin
                    baud_cnt_d = BAUD_LD;
                    if (rx_s) begin
                        // Line back high at mid start bit: treat as noise.
                        baud_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                baud_cnt_d = baud_dec;
                if (baud_dec == '0) begin
                    baud_cnt_d = BAUD_LD;
                    shift_d    = {rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                baud_cnt_d = baud_dec;
                if (baud_dec == '0) begin
                    baud_cnt_d = '0;
                    data_d     = shift_q;
                    set_d      = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                    err_pend_d = ~rx_s;
`endif
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion in the same cycle as clr_rdy must not be lost.
        rdy_d = rdy_q;
        if (clr_rdy) rdy_d = 1'b0;
        if (set_q)   rdy_d = 1'b1;

`ifdef UART_RX_FRAME_ERR_EN
        ferr_d = ferr_q;
        if (clr_rdy) ferr_d = 1'b0;
        if (set_q)   ferr_d = err_pend_q;
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            set_q      <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            err_pend_q <= 1'b0;
            ferr_q     <= 1'b0;
`endif
        end else begin
            rx_prev_q  <= rx_s;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            set_q      <= set_d;
            rdy_q      <= rdy_d;
`ifdef UART_RX_FRAME_ERR_EN
            err_pend_q <= err_pend_d;
            ferr_q     <= ferr_d;
`endif
        end
    end

    assign rdy     = rdy_q;
    assign rx_data = data_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver using a shortened bit time.
// Frames are queued on a scoreboard as they are driven and checked when the
// receiver reports a byte.
`timescale 1ns/1ps
module tb_uart_frame_receiver;

    localparam int unsigned B   = 64;
    localparam int unsigned H   = 32;
    localparam int          LAT = H + 9 * B + 3;

    typedef struct {
        logic [7:0] d;
        logic       err;
        int         start;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       RX      = 1'b1;
    logic       clr_man = 1'b0;
    logic       tie     = 1'b1;
    logic       clr_rdy;
    logic       rdy;
    logic [7:0] rx_data;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   hi_cnt   = 0;
    int   cyc      = 0;
    logic       prev_rdy  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    assign clr_rdy = tie ? rdy : clr_man;

    uart_frame_receiver #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rdy       (rdy),
        .rx_data   (rx_data)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: a report is a rising rdy, or rx_data overwritten while rdy is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy  <= 1'b0;
            prev_data <= 8'h00;
        end else begin
            if (rdy && (!prev_rdy || rx_data != prev_data)) begin : report
                exp_t e;
                int   lat;
                n_out <= n_out + 1;
                check_eq("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() != 0) begin
                    e   = sb.pop_front();
                    lat = cyc - e.start;
                    check_eq("rx_data", {24'h0, rx_data}, {24'h0, e.d});
                    check_eq("latency_window",
                             (lat >= LAT - 1 && lat <= LAT + 1) ? 32'd1 : 32'd0, 32'd1);
`ifdef UART_RX_FRAME_ERR_EN
                    check_eq("frame_err", {31'h0, frame_err}, {31'h0, e.err});
`endif
                end
            end
            hi_cnt    <= hi_cnt + (rdy ? 1 : 0);
            prev_rdy  <= rdy;
            prev_data <= rx_data;
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        sb.push_back('{d: d, err: ~stop, start: cyc});
        RX = 1'b0;
        idle(B);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            idle(B);
        end
        RX = stop;
        idle(B);
        RX = 1'b1;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 4 * B) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n0;
        int h0;
        logic [7:0] pat;

        // Reset state.
        idle(5);
        check_eq("reset_rdy", {31'h0, rdy}, 32'd0);
        check_eq("reset_data", {24'h0, rx_data}, 32'h00);
        rst_n = 1'b1;
        idle(50000);
        check_eq("idle_rdy", {31'h0, rdy}, 32'd0);
        check_eq("idle_no_output", n_out, 32'd0);

        // Single frame with clr_rdy tied to rdy: one-cycle strobe.
        h0 = hi_cnt;
        drive_frame(8'hA5, 1'b1);
        idle(B);
        wait_drain();
        check_eq("rdy_one_cycle", hi_cnt - h0, 32'd1);
        check_eq("rdy_cleared", {31'h0, rdy}, 32'd0);

        // Short low pulse is rejected at the start-bit sample.
        n0 = n_out;
        RX = 1'b0;
        idle(H / 2);
        RX = 1'b1;
        idle(4 * B);
        check_eq("glitch_no_output", n_out - n0, 32'd0);
        check_eq("glitch_rdy", {31'h0, rdy}, 32'd0);

        // Break: exactly one zero frame while the line stays low.
        n0 = n_out;
        sb.push_back('{d: 8'h00, err: 1'b1, start: cyc});
        RX = 1'b0;
        idle(20 * B);
        RX = 1'b1;
        idle(4 * B);
        wait_drain();
        check_eq("break_one_frame", n_out - n0, 32'd1);

        // Back-to-back frames with no clearing.
        tie = 1'b0;
        clr_man = 1'b0;
        drive_frame(8'h3C, 1'b1);
        check_eq("rdy_held", {31'h0, rdy}, 32'd1);
        drive_frame(8'hC3, 1'b1);
        idle(B);
        wait_drain();
        check_eq("rdy_still_set", {31'h0, rdy}, 32'd1);
        check_eq("b2b_data", {24'h0, rx_data}, 32'hC3);
        clr_man = 1'b1;
        idle(1);
        clr_man = 1'b0;
        idle(1);
        check_eq("clr_rdy", {31'h0, rdy}, 32'd0);
        check_eq("data_hold", {24'h0, rx_data}, 32'hC3);
        tie = 1'b1;
        idle(2 * B);

        // Stop bit forced low.
        drive_frame(8'h7E, 1'b0);
        idle(B);
        wait_drain();
        check_eq("ferr_data", {24'h0, rx_data}, 32'h7E);

        // Reset in the middle of data bit 4 abandons the frame.
        pat = 8'h5A;
        RX = 1'b0;
        idle(B);
        for (int i = 0; i < 4; i++) begin
            RX = pat[i];
            idle(B);
        end
        RX = pat[4];
        idle(B / 2);
        rst_n = 1'b0;
        RX = 1'b1;
        idle(3);
        check_eq("midreset_rdy", {31'h0, rdy}, 32'd0);
        check_eq("midreset_data", {24'h0, rx_data}, 32'h00);
        rst_n = 1'b1;
        idle(2 * B);
        n0 = n_out;
        drive_frame(8'h11, 1'b1);
        idle(B);
        wait_drain();
        check_eq("post_reset_frame", n_out - n0, 32'd1);
        check_eq("post_reset_data", {24'h0, rx_data}, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
